// File: rtl/rs_pkg.sv
// +----------------------------------------------------------------------------+
// | rs_pkg : shared GF(2^8) constants and FSM state type for the RS syndrome  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package rs_pkg;

  localparam int N_SYND = 4;
  localparam int GF_W   = 8;

  localparam logic [GF_W:0] PRIM_POLY = 9'h11D;

  // alpha^j for j = 0..3, packed with alpha^0 in the low byte
  localparam logic [N_SYND*GF_W-1:0] ALPHA_POW = {8'h08, 8'h04, 8'h02, 8'h01};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [GF_W-1:0] alpha_pow(input logic [1:0] j);
    return ALPHA_POW[j*GF_W +: GF_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/gf256_mult.sv
// +----------------------------------------------------------------------------+
// | gf256_mult : combinational GF(2^8) multiplier, X = A * B mod PRIM_POLY     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module gf256_mult
  import rs_pkg::*;
(
  input  logic [GF_W-1:0] A,
  input  logic [GF_W-1:0] B,
  output logic [GF_W-1:0] X
);

  logic [GF_W-1:0] w_acc;
  logic [GF_W-1:0] w_a_sh;

  // shift-and-add: A is multiplied by alpha each step, reducing on overflow
  always_comb begin
    w_acc  = '0;
    w_a_sh = A;
    for (int i = 0; i < GF_W; i++) begin
      if (B[i]) w_acc = w_acc ^ w_a_sh;
      w_a_sh = {w_a_sh[GF_W-2:0], 1'b0} ^
               (w_a_sh[GF_W-1] ? PRIM_POLY[GF_W-1:0] : {GF_W{1'b0}});
    end
    X = w_acc;
  end

endmodule

`default_nettype wire

// File: rtl/rs_syndrome_sched.sv
// +----------------------------------------------------------------------------+
// | rs_syndrome_sched : byte-serial S0..S3 syndrome engine, one shared GF mult |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rs_syndrome_sched
  import rs_pkg::*;
#(
  parameter int N_BYTES = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [GF_W-1:0]          in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [N_SYND*GF_W-1:0]   out_synd,
  output logic                     out_err,
  input  logic                     out_ready
);

  localparam logic [7:0] C_LAST_IDX = 8'(N_BYTES - 1);

  state_t                       r_state;
  logic [1:0]                   r_j;
  logic [7:0]                   r_byte_cnt;
  logic [GF_W-1:0]              r_byte;
  logic [N_SYND-1:0][GF_W-1:0]  r_synd;

  logic [GF_W-1:0] w_mult_a;
  logic [GF_W-1:0] w_mult_b;
  logic [GF_W-1:0] w_mult_x;

  assign w_mult_a = r_synd[r_j];
  assign w_mult_b = alpha_pow(r_j);

  gf256_mult u_mult (
    .A (w_mult_a),
    .B (w_mult_b),
    .X (w_mult_x)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_j        <= 2'd0;
      r_byte_cnt <= 8'd0;
      r_byte     <= '0;
      r_synd     <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && in_ready) begin
            r_byte   <= in_data;
            r_j      <= 2'd0;
            in_ready <= 1'b0;
            r_state  <= MAC;
          end
        end
        MAC: begin
          r_synd[r_j] <= w_mult_x ^ r_byte;
          r_j         <= r_j + 2'd1;
          if (r_j == 2'd3) begin
            if (r_byte_cnt == C_LAST_IDX) begin
              out_valid <= 1'b1;
              r_state   <= DONE;
            end else begin
              r_byte_cnt <= r_byte_cnt + 8'd1;
              in_ready   <= 1'b1;
              r_state    <= IDLE;
            end
          end
        end
        DONE: begin
          // syndromes stay frozen until the consumer takes them
          if (out_ready) begin
            r_synd     <= '0;
            r_byte_cnt <= 8'd0;
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state  <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign out_synd = r_synd;
  assign out_err  = |r_synd;

endmodule

`default_nettype wire

// File: doc/rs_syndrome_sched.md
# rs_syndrome_sched

Sequencer for the CIRC Reed-Solomon front end: accepts one received codeword byte-serially and computes its four syndromes S0..S3 by time-sharing a single `gf256_mult` instance across the four Horner accumulators. It sits between the deinterleaver byte stream and the error locator. A nonzero result flags the codeword for correction. One instance serves C1 (RS(32,28)) or C2 (RS(28,24)) via a parameter.

## Interface
Parameters:
- `N_BYTES`, default 32: codeword length in bytes; 32 for C1, 28 for C2; legal range 2..255.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  `in_data` holds a codeword byte.
- `in_data`  in  8  received byte, first byte = highest-degree coefficient.
- `in_ready`  out  1  block can accept a byte this cycle.
- `out_valid`  out  1  syndromes of a complete codeword are available.
- `out_synd`  out  32  {S3, S2, S1, S0}, S0 in bits [7:0].
- `out_err`  out  1  OR of all syndrome bits; valid only while `out_valid`.
- `out_ready`  in  1  consumer accepts the result.

## Operation
- Field GF(2^8), primitive polynomial 0x11D, alpha = 0x02. S_j = sum of r_i * alpha^(j*(N_BYTES-1-i)), j = 0..3.
- Horner update per byte b, per j: S_j <= gf256_mult(S_j, alpha^j) XOR b, using alpha^0..3 = 0x01, 0x02, 0x04, 0x08.
- There is exactly one multiplier. All four updates, including j=0, go through it: a mux on A selects S_j and a mux on B selects alpha^j.
- State machine:
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, latch `in_data` into the byte register, set j=0, and go to MAC.
  - MAC: one accumulator updated per cycle for j = 0,1,2,3.
    - After j=3, if `byte_cnt` == N_BYTES-1, go to DONE; otherwise increment `byte_cnt` and return to IDLE.
  - DONE: `out_valid`=1 and `in_ready`=0.
    - On `out_ready`, clear S0..S3 and `byte_cnt` to 0, then go to IDLE.
    - While `out_ready` is low, `out_synd` and `out_err` hold stable.
- `in_data` is sampled only on the handshake cycle. `in_valid` while not ready is ignored and does not need to be held by protocol, although upstream holds it.
- Accumulators start at 0x00 for each codeword. No explicit preload is needed.
- `byte_cnt` is 8 bits, compared against N_BYTES-1, and never wraps.
- Reset in any state: state goes to IDLE, S0..S3 = 0, `byte_cnt` = 0, j = 0, byte register = 0. Any partial codeword is discarded.

## Timing
- Reset values: `in_ready`=1 in the first cycle after reset release; `out_valid`=0; `out_synd`=0; `out_err`=0.
- Throughput: one byte per 5 cycles (1 accept cycle + 4 MAC cycles). `in_ready` is low for the 4 MAC cycles.
- Byte accepted at edge t: S_j is updated at edge t+1+j, and `in_ready` rises in the cycle after edge t+4.
- Last byte accepted at edge t: `out_valid` is asserted in the cycle after edge t+4. Codeword latency is 5*N_BYTES cycles from the first accept to `out_valid`, with no stalls.
- Result handshake at edge t: `out_valid`=0 and `in_ready`=1 after edge t. A new codeword byte can be accepted at edge t+1 at the earliest.
- `out_err` is a registered or combinational function of the held S regs. Either way it is stable throughout `out_valid`.

## Structure
- Shared package `rs_pkg`:
  - primitive polynomial 0x11D;
  - ALPHA_POW table for j = 0..3;
  - state enum {IDLE, MAC, DONE};
  - constants N_SYND=4 and GF_W=8.
- One sub-module: the existing combinational `gf256_mult` (ports A, B, X), instantiated once.
- Everything else is inline: FSM, j counter (2 bits), `byte_cnt`, four 8-bit accumulators, byte register, and the A/B muxes.

## Test plan
- Zero codeword: 32 bytes of 0x00 → `out_synd`=0x00000000, `out_err`=0, `out_valid` in the cycle after edge 160 counted from the first accept.
- Single error at degree 1: all 0x00 except byte index 30 = 0x01 → `out_synd`=0x08040201, `out_err`=1.
- Single error at degree 31: byte index 0 = 0x01, rest 0x00. alpha^31=0xC0, alpha^62 and alpha^93 come from the same table. Required: S0=0x01, S1=0xC0, S2 and S3 match the bench's golden GF model, `out_err`=1.
- Backpressure: hold `out_ready`=0 for 20 cycles in DONE → `out_synd` stable and `in_ready`=0 throughout, and an `in_valid` pulse is ignored. After release, the next codeword's syndromes are correct; for the zero codeword, 0x00000000.
- Reset mid-frame: assert `rst` after 10 bytes → `in_ready`=1, `out_valid`=0, `out_synd`=0 on the next cycle. A following full zero codeword yields 0x00000000.
- C2 configuration: N_BYTES=28 with random bytes against the golden model. Compare all four syndromes over 1000 codewords with random `in_valid`/`out_ready` gaps.
